// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage
// ID/EX pipeline register for the 5-stage MIPS core. It also contains the
// load-use hazard detector and the EX-stage forwarding unit.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_*                            decoded instruction from ID
//   flush                           taken branch/jump; squash the ID slot
//   ex_mem_rd/_reg_write            EX/MEM destination (forwarding source)
//   mem_wb_rd/_reg_write            MEM/WB destination (forwarding source)
//   ex_*                            registered operands/controls for EX
//   forward_a, forward_b            ALU operand mux selects (10 EX/MEM, 01 MEM/WB, 00 RF)
//   stall                           freeze PC and IF/ID this cycle
//   stall_count, flush_count        saturating event counters
module id_ex_hazard_stage #(
  parameter int REG_W       = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_read_data_1,
  input  logic [REG_W-1:0]       id_read_data_2,
  input  logic [REG_W-1:0]       id_imm,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [2:0]             id_alu_op,
  input  logic                   id_alu_src,
  input  logic                   id_reg_dst,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic                   id_reg_write,
  input  logic                   id_mem_to_reg,
  input  logic                   flush,
  input  logic [4:0]             ex_mem_rd,
  input  logic                   ex_mem_reg_write,
  input  logic [4:0]             mem_wb_rd,
  input  logic                   mem_wb_reg_write,
  output logic                   ex_valid,
  output logic [REG_W-1:0]       ex_read_data_1,
  output logic [REG_W-1:0]       ex_read_data_2,
  output logic [REG_W-1:0]       ex_imm,
  output logic [4:0]             ex_rs,
  output logic [4:0]             ex_rt,
  output logic [2:0]             ex_alu_op,
  output logic                   ex_alu_src,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_reg_write,
  output logic                   ex_mem_to_reg,
  output logic [4:0]             ex_write_reg,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [STALL_CNT_W-1:0] flush_count
);

  logic bubble;

  // The rt compare is deliberately unconditional: stores and I-types that
  // do not read rt may stall needlessly, but no dependency is ever missed.
  assign stall = ex_mem_read & ex_valid & (ex_write_reg != 5'd0) & id_valid &
                 ((ex_write_reg == id_rs) | (ex_write_reg == id_rt));

  assign bubble = flush | stall;

  // EX/MEM is checked first so the youngest result wins.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rs))
      forward_a = 2'b10;
    else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rs))
      forward_a = 2'b01;
    if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rt))
      forward_b = 2'b10;
    else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rt))
      forward_b = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_imm         <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_alu_op      <= '0;
      ex_alu_src     <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_write_reg   <= '0;
    end else if (bubble) begin
      // A bubble is a fully zeroed slot so it can never forward or stall.
      ex_valid       <= 1'b0;
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_imm         <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_alu_op      <= '0;
      ex_alu_src     <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_write_reg   <= '0;
    end else begin
      ex_valid       <= id_valid;
      ex_read_data_1 <= id_read_data_1;
      ex_read_data_2 <= id_read_data_2;
      ex_imm         <= id_imm;
      ex_rs          <= id_rs;
      ex_rt          <= id_rt;
      ex_alu_op      <= id_alu_op;
      ex_alu_src     <= id_alu_src;
      ex_mem_read    <= id_mem_read;
      ex_mem_write   <= id_mem_write;
      ex_reg_write   <= id_reg_write;
      ex_mem_to_reg  <= id_mem_to_reg;
      ex_write_reg   <= id_reg_dst ? id_rd : id_rt;
    end
  end

  // A stall coinciding with a flush is accounted as a flush only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && !flush && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_W'(1);
      if (flush && (flush_count != '1))
        flush_count <= flush_count + STALL_CNT_W'(1);
    end
  end

endmodule
